// File: rtl/zpb_pkg.sv
// Shared definitions for the push-button front end: channel FSM states and width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package zpb_pkg;

  // Per-channel debounce / hold states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEB_DN = 3'd1,
    HELD   = 3'd2,
    REPEAT = 3'd3,
    DEB_UP = 3'd4
  } zpb_state_t;

  // Number of bits needed to hold values 0..value-1 (never less than 1)
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/zpb_channel.sv
// One button channel: debounce FSM with tick counter, emits level and press/release/long/repeat strobes.
// Latency: outputs registered, change one clk after the deciding p/tick sample.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module zpb_channel
  import zpb_pkg::*;
#(
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic p,
  output logic level,
  output logic press_stb,
  output logic release_stb,
  output logic long_stb,
  output logic repeat_stb
);

  localparam int CW = clog2(max3(DEB_TICKS, LONG_TICKS, REP_TICKS) + 1);
  localparam logic [CW-1:0] DEB_C  = CW'(DEB_TICKS);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_TICKS);
  localparam logic [CW-1:0] REP_C  = CW'(REP_TICKS);

  zpb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          from_rep, from_rep_n;
  logic          press_n, release_n, long_n, repeat_n;
  logic          level_n;

  // Saturating increment: equality compares make a wrap impossible in practice, this is a guard
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      from_rep    <= 1'b0;
      level       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      long_stb    <= 1'b0;
      repeat_stb  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      from_rep    <= from_rep_n;
      level       <= level_n;
      press_stb   <= press_n;
      release_stb <= release_n;
      long_stb    <= long_n;
      repeat_stb  <= repeat_n;
    end
  end

  // Next state: a change of p always wins over a simultaneous tick
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    from_rep_n = from_rep;
    press_n    = 1'b0;
    release_n  = 1'b0;
    long_n     = 1'b0;
    repeat_n   = 1'b0;
    case (state)
      IDLE: begin
        if (p) begin
          state_n = DEB_DN;
          cnt_n   = '0;
        end
      end
      DEB_DN: begin
        if (!p) begin
          state_n = IDLE;
        end else if (tick) begin
          if (cnt_inc == DEB_C) begin
            state_n = HELD;
            press_n = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      HELD: begin
        if (!p) begin
          state_n    = DEB_UP;
          cnt_n      = '0;
          from_rep_n = 1'b0;
        end else if (tick) begin
          if (cnt_inc == LONG_C) begin
            state_n = REPEAT;
            long_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      REPEAT: begin
        if (!p) begin
          state_n    = DEB_UP;
          cnt_n      = '0;
          from_rep_n = 1'b1;
        end else if ((REP_TICKS != 0) && tick) begin
          if (cnt_inc == REP_C) begin
            repeat_n = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      DEB_UP: begin
        if (p) begin
          // Release glitch rejected: resume whichever held phase we came from
          state_n = from_rep ? REPEAT : HELD;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt_inc == DEB_C) begin
            state_n   = IDLE;
            release_n = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Disable drops the channel silently: no release strobe is produced
    if (!en) begin
      state_n    = IDLE;
      cnt_n      = '0;
      from_rep_n = 1'b0;
      press_n    = 1'b0;
      release_n  = 1'b0;
      long_n     = 1'b0;
      repeat_n   = 1'b0;
    end
    level_n = (state_n == HELD) || (state_n == REPEAT) || (state_n == DEB_UP);
  end

endmodule

// File: rtl/zpush_button_array.sv
// N-channel push-button front end: 2-FF synchronisers, shared tick prescaler, per-channel debounce FSMs.
// Latency: pin to FSM 2 clk; strobes registered, press after DEB_TICKS stable ticks.
// Backpressure: none; all outputs are single-cycle strobes or a level.
module zpush_button_array
  import zpb_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int TICK_CYC   = 50000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_BTN-1:0] iButton,
  output logic [NUM_BTN-1:0] oLevel,
  output logic [NUM_BTN-1:0] oPress,
  output logic [NUM_BTN-1:0] oRelease,
  output logic [NUM_BTN-1:0] oLong,
  output logic [NUM_BTN-1:0] oRepeat
);

  localparam int                 PW       = clog2(TICK_CYC);
  localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_CYC - 1);
  // Pin value of a released button; also the synchroniser reset value
  localparam logic [NUM_BTN-1:0] REL_VAL  = {NUM_BTN{ACTIVE_LOW != 0}};

  logic [NUM_BTN-1:0] sync_q1, sync_q2, p;
  logic [PW-1:0]      pre;
  logic               tick;

  // Two-stage synchroniser; keeps running while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= REL_VAL;
      sync_q2 <= REL_VAL;
    end else begin
      sync_q1 <= iButton;
      sync_q2 <= sync_q1;
    end
  end

  // Normalise polarity so that 1 always means pressed
  assign p = sync_q2 ^ REL_VAL;

  // Shared timebase: free-running 0..TICK_CYC-1, parked at 0 while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (!en) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = en && (pre == PRE_LAST);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    zpb_channel #(
      .DEB_TICKS (DEB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS (REP_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .tick       (tick),
      .p          (p[i]),
      .level      (oLevel[i]),
      .press_stb  (oPress[i]),
      .release_stb(oRelease[i]),
      .long_stb   (oLong[i]),
      .repeat_stb (oRepeat[i])
    );
  end

endmodule

// File: tb/tb_zpush_button_array.sv
// Bench for zpush_button_array: two instances (active-low with repeat, active-high without repeat)
// driven by the same logical button pattern; expected event times derived from a tick log.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_zpush_button_array;

  localparam int TC  = 10;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] lvl[2], prs[2], rls[2], lng[2], rpt[2];

  always #5 clk = ~clk;

  zpush_button_array #(.NUM_BTN(4), .ACTIVE_LOW(1), .TICK_CYC(TC), .DEB_TICKS(DEB),
                       .LONG_TICKS(LNG), .REP_TICKS(REP)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .iButton(~btn),
    .oLevel(lvl[0]), .oPress(prs[0]), .oRelease(rls[0]), .oLong(lng[0]), .oRepeat(rpt[0]));

  zpush_button_array #(.NUM_BTN(4), .ACTIVE_LOW(0), .TICK_CYC(TC), .DEB_TICKS(DEB),
                       .LONG_TICKS(LNG), .REP_TICKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .iButton(btn),
    .oLevel(lvl[1]), .oPress(prs[1]), .oRelease(rls[1]), .oLong(lng[1]), .oRepeat(rpt[1]));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pre_m = 0;
  int tick_q[$];
  int n_prs[2][4], n_rls[2][4], n_lng[2][4], n_rpt[2][4];
  int t_prs[2][4], t_rls[2][4], t_lng[2][4];
  int t_rpt[2][4][8];
  logic [3:0] prs_vec[2];
  logic [3:0] prev_prs[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference timebase: the prescaler counts enabled cycles; log the edge number of every tick
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n || !en) begin
      pre_m = 0;
    end else if (pre_m == TC - 1) begin
      tick_q.push_back(cyc);
      pre_m = 0;
    end else begin
      pre_m = pre_m + 1;
    end
  end

  // Event recorder plus per-cycle strobe sanity checks
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (prs[d] != 4'b0000) prs_vec[d] = prs[d];
        for (int c = 0; c < 4; c++) begin
          if (prs[d][c]) begin
            n_prs[d][c]++; t_prs[d][c] = cyc;
            chk("press_single_cycle", 32'(prev_prs[d][c]), 0);
          end
          if (rls[d][c]) begin n_rls[d][c]++; t_rls[d][c] = cyc; end
          if (lng[d][c]) begin n_lng[d][c]++; t_lng[d][c] = cyc; end
          if (rpt[d][c]) begin
            if (n_rpt[d][c] < 8) t_rpt[d][c][n_rpt[d][c]] = cyc;
            n_rpt[d][c]++;
          end
          if (prs[d][c] | lng[d][c] | rpt[d][c])
            chk("strobe_exclusive", 32'(prs[d][c]) + 32'(lng[d][c]) + 32'(rpt[d][c]), 1);
        end
      end
    end
    for (int d = 0; d < 2; d++) prev_prs[d] = prs[d];
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      prs_vec[d] = 4'b0000;
      for (int c = 0; c < 4; c++) begin
        n_prs[d][c] = 0; n_rls[d][c] = 0; n_lng[d][c] = 0; n_rpt[d][c] = 0;
        t_prs[d][c] = -1; t_rls[d][c] = -1; t_lng[d][c] = -1;
      end
    end
  endtask

  // Edge of the n-th logged tick at or after edge 'from' (-1 if not yet seen)
  function automatic int nth_tick(input int from, input int n);
    int k;
    k = 0;
    foreach (tick_q[i]) begin
      if (tick_q[i] >= from) begin
        k++;
        if (k == n) return tick_q[i];
      end
    end
    return -1;
  endfunction

  // Repeat strobes expected between the long strobe and the last edge p was still 1
  function automatic int count_reps(input int t_long, input int last_edge);
    int j;
    int e;
    j = 1;
    forever begin
      e = nth_tick(t_long + 1, REP * j);
      if (e < 0 || e > last_edge) break;
      j++;
    end
    return j - 1;
  endfunction

  int k, k2, e_prs, e_rls, e_lng, e_rep;

  initial begin
    clear_stats();
    for (int d = 0; d < 2; d++) prev_prs[d] = 4'b0000;
    wait_cyc(3);
    for (int d = 0; d < 2; d++)
      chk("reset_outputs", 32'({lvl[d], prs[d], rls[d], lng[d], rpt[d]}), 0);
    rst_n = 1'b1;
    en = 1'b1;
    wait_cyc(2 + $urandom_range(0, 9));

    // Clean press on ch0, held ~100 clk, then released
    clear_stats();
    k = cyc; btn[0] = 1'b1;
    wait_cyc(60);
    e_prs = nth_tick(k + 4, DEB);
    for (int d = 0; d < 2; d++) begin
      chk("clean_press_count", n_prs[d][0], 1);
      chk("clean_press_time", t_prs[d][0], e_prs);
      chk("clean_level_high", 32'(lvl[d][0]), 1);
    end
    wait_cyc(40 + $urandom_range(0, 5));
    k2 = cyc; btn[0] = 1'b0;
    wait_cyc(60);
    e_rls = nth_tick(k2 + 4, DEB);
    for (int d = 0; d < 2; d++) begin
      chk("clean_release_count", n_rls[d][0], 1);
      chk("clean_release_time", t_rls[d][0], e_rls);
      chk("clean_level_low", 32'(lvl[d][0]), 0);
      chk("clean_no_long", n_lng[d][0], 0);
    end

    // Bounce on ch1: random short toggles, then stable pressed
    clear_stats();
    k = cyc;
    while (cyc - k < 60) begin
      btn[1] = ~btn[1];
      wait_cyc($urandom_range(3, 20));
    end
    btn[1] = 1'b0;
    wait_cyc(3);
    for (int d = 0; d < 2; d++) chk("bounce_no_strobe", n_prs[d][1] + n_rls[d][1], 0);
    k = cyc; btn[1] = 1'b1;
    wait_cyc(60);
    e_prs = nth_tick(k + 4, DEB);
    for (int d = 0; d < 2; d++) begin
      chk("bounce_press_count", n_prs[d][1], 1);
      chk("bounce_press_time", t_prs[d][1], e_prs);
    end
    btn[1] = 1'b0;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) chk("bounce_release_count", n_rls[d][1], 1);

    // Long hold on ch2 for 400 clk: long strobe, repeats on dut_a only
    clear_stats();
    wait_cyc($urandom_range(0, 9));
    k = cyc; btn[2] = 1'b1;
    wait_cyc(400);
    k2 = cyc; btn[2] = 1'b0;
    wait_cyc(60);
    e_prs = nth_tick(k + 4, DEB);
    e_lng = nth_tick(e_prs + 1, LNG);
    e_rep = count_reps(e_lng, k2 + 2);
    chk("long_rep_model_sanity", e_rep, 3);
    for (int d = 0; d < 2; d++) begin
      chk("long_press_count", n_prs[d][2], 1);
      chk("long_press_time", t_prs[d][2], e_prs);
      chk("long_count", n_lng[d][2], 1);
      chk("long_time", t_lng[d][2], e_lng);
      chk("long_release_count", n_rls[d][2], 1);
      chk("long_release_time", t_rls[d][2], nth_tick(k2 + 4, DEB));
    end
    chk("repeat_count_a", n_rpt[0][2], e_rep);
    chk("repeat_first_time_a", t_rpt[0][2][0], nth_tick(e_lng + 1, REP));
    chk("repeat_last_time_a", t_rpt[0][2][2], nth_tick(e_lng + 1, 3 * REP));
    chk("repeat_count_b_disabled", n_rpt[1][2], 0);

    // Release glitch on ch0: 15 clk release is ignored
    clear_stats();
    btn[0] = 1'b1;
    wait_cyc(60);
    btn[0] = 1'b0;
    wait_cyc(15);
    btn[0] = 1'b1;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) begin
      chk("glitch_no_release", n_rls[d][0], 0);
      chk("glitch_single_press", n_prs[d][0], 1);
      chk("glitch_level_held", 32'(lvl[d][0]), 1);
    end
    btn[0] = 1'b0;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) chk("glitch_final_release", n_rls[d][0], 1);

    // Simultaneous ch0/ch3 press, then enable drop and re-enable while held
    clear_stats();
    wait_cyc($urandom_range(0, 9));
    k = cyc; btn = 4'b1001;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) begin
      chk("multi_press_vector", 32'(prs_vec[d]), 9);
      chk("multi_press_time", t_prs[d][3], nth_tick(k + 4, DEB));
    end
    en = 1'b0;
    wait_cyc(2);
    for (int d = 0; d < 2; d++) begin
      chk("en_off_level", 32'(lvl[d]), 0);
      chk("en_off_no_release", n_rls[d][0] + n_rls[d][3], 0);
    end
    wait_cyc($urandom_range(5, 30));
    k = cyc; en = 1'b1;
    wait_cyc(60);
    e_prs = nth_tick(k + 2, DEB);
    for (int d = 0; d < 2; d++) begin
      chk("reenable_press_count", n_prs[d][0] + n_prs[d][3], 4);
      chk("reenable_press_time", t_prs[d][0], e_prs);
      chk("reenable_level", 32'(lvl[d]), 9);
    end
    btn = 4'b0000;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) chk("multi_release_vector", n_rls[d][0] + n_rls[d][3], 2);

    // Async reset while ch2 is in the repeat phase, pin kept held
    clear_stats();
    btn[2] = 1'b1;
    wait_cyc(300);
    for (int d = 0; d < 2; d++) begin
      chk("pre_reset_long_seen", n_lng[d][2], 1);
      chk("pre_reset_level", 32'(lvl[d][2]), 1);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk("reset_immediate_clear", 32'({lvl[d], prs[d], rls[d], lng[d], rpt[d]}), 0);
    wait_cyc(3);
    clear_stats();
    k = cyc; rst_n = 1'b1;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) begin
      chk("post_reset_press_count", n_prs[d][2], 1);
      chk("post_reset_press_time", t_prs[d][2], nth_tick(k + 4, DEB));
    end
    btn[2] = 1'b0;
    wait_cyc(60);
    for (int d = 0; d < 2; d++) chk("post_reset_release", n_rls[d][2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
